// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants: default trellis geometry, metric packing helper, normalisation bit.
package viterbi_pkg;

  localparam int DEF_NUM_STATES = 4;
  localparam int DEF_PM_WIDTH   = 8;
  localparam int DEF_TBL        = 15;

  // Bit cleared from every metric when all metrics have it set.
  localparam int NORM_MSB = DEF_PM_WIDTH - 1;

  // LSB position of state s inside a flattened metric vector.
  function automatic int pm_idx(input int s, input int w = DEF_PM_WIDTH);
    return s * w;
  endfunction

endpackage

// File: rtl/pm_argmin.sv
// Combinational minimum-finder over N packed W-bit values; lowest index wins ties.
// Zero latency, no state, no flow control.
module pm_argmin
  import viterbi_pkg::*;
#(
  parameter int N = DEF_NUM_STATES,
  parameter int W = DEF_PM_WIDTH,
  localparam int SW = $clog2(N)
) (
  input  logic [N*W-1:0] vals_i,
  output logic [SW-1:0]  idx_o,
  output logic [W-1:0]   min_o
);

  // Heap-ordered tree: leaves at N-1..2N-2, left child always covers lower indices.
  logic [W-1:0]  node_val [2*N-1];
  logic [SW-1:0] node_idx [2*N-1];

  always_comb begin
    for (int s = 0; s < N; s++) begin
      node_val[N-1+s] = vals_i[pm_idx(s, W) +: W];
      node_idx[N-1+s] = SW'(s);
    end
    for (int i = N - 2; i >= 0; i--) begin
      if (node_val[2*i+2] < node_val[2*i+1]) begin
        node_val[i] = node_val[2*i+2];
        node_idx[i] = node_idx[2*i+2];
      end else begin
        node_val[i] = node_val[2*i+1];
        node_idx[i] = node_idx[2*i+1];
      end
    end
    idx_o = node_idx[0];
    min_o = node_val[0];
  end

endmodule

// File: rtl/pmu_ring.sv
// Path-metric store with renormalisation, best-state tracking and a TBL-deep decision ring.
// Writes take effect one cycle later, reads are combinational; no backpressure.
module pmu_ring
  import viterbi_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int PM_WIDTH   = DEF_PM_WIDTH,
  parameter int TBL        = DEF_TBL,
  parameter int INIT_PM    = 0,
  localparam int AW = $clog2(TBL),
  localparam int SW = $clog2(NUM_STATES),
  localparam int FW = $clog2(TBL + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_i,
  input  logic                           flush_i,
  input  logic [NUM_STATES-1:0]          dec_bits_i,
  input  logic [NUM_STATES*PM_WIDTH-1:0] pm_new_i,
  input  logic [AW-1:0]                  read_addr_i,
  output logic [NUM_STATES*PM_WIDTH-1:0] pm_current_o,
  output logic [NUM_STATES-1:0]          read_data_o,
  output logic [SW-1:0]                  best_state_o,
  output logic [PM_WIDTH-1:0]            best_pm_o,
  output logic [FW-1:0]                  fill_o,
  output logic                           full_o,
  output logic                           norm_o
);

  localparam int MSB = NORM_MSB + (PM_WIDTH - DEF_PM_WIDTH);

  logic [PM_WIDTH-1:0]   pm_q [NUM_STATES];
  logic [PM_WIDTH-1:0]   pm_d [NUM_STATES];
  logic [NUM_STATES-1:0] mem_q [TBL];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  norm_q, norm_d;
  logic [SW-1:0]         best_state_q, best_state_d;
  logic [PM_WIDTH-1:0]   best_pm_q, best_pm_d;

  logic                           all_msb;
  logic [NUM_STATES*PM_WIDTH-1:0] pm_norm;
  logic [SW-1:0]                  am_idx;
  logic [PM_WIDTH-1:0]            am_val;
  logic [AW-1:0]                  ptr_base;
  logic [FW-1:0]                  fill_base;
  int                             rd_sum;
  logic [AW-1:0]                  rd_phys;
  logic                           rd_ok;

  // Renormalise only when every metric has crossed half range, so ordering is preserved.
  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < NUM_STATES; s++) begin
      all_msb = all_msb & pm_new_i[pm_idx(s, PM_WIDTH) + MSB];
    end
    pm_norm = pm_new_i;
    if (all_msb) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_norm[pm_idx(s, PM_WIDTH) + MSB] = 1'b0;
      end
    end
  end

  pm_argmin #(
    .N (NUM_STATES),
    .W (PM_WIDTH)
  ) u_argmin (
    .vals_i (pm_norm),
    .idx_o  (am_idx),
    .min_o  (am_val)
  );

  always_comb begin
    ptr_base     = flush_i ? '0 : wr_ptr_q;
    fill_base    = flush_i ? '0 : fill_q;
    wr_ptr_d     = ptr_base;
    fill_d       = fill_base;
    norm_d       = 1'b0;
    best_state_d = best_state_q;
    best_pm_d    = best_pm_q;
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_d[s] = pm_q[s];
    end

    if (flush_i) begin
      best_state_d = '0;
      best_pm_d    = '0;
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_d[s] = (s == 0) ? '0 : PM_WIDTH'(INIT_PM);
      end
    end

    if (valid_i) begin
      wr_ptr_d     = (ptr_base == AW'(TBL - 1)) ? '0 : ptr_base + AW'(1);
      fill_d       = (fill_base == FW'(TBL)) ? fill_base : fill_base + FW'(1);
      norm_d       = all_msb;
      best_state_d = am_idx;
      best_pm_d    = am_val;
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_d[s] = pm_norm[pm_idx(s, PM_WIDTH) +: PM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      norm_q       <= 1'b0;
      best_state_q <= '0;
      best_pm_q    <= '0;
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s] <= (s == 0) ? '0 : PM_WIDTH'(INIT_PM);
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      norm_q       <= norm_d;
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s] <= pm_d[s];
      end
    end
  end

  // Ring contents are never cleared; stale slots are hidden by the fill mask.
  always_ff @(posedge clk) begin
    if (!rst && valid_i) begin
      mem_q[ptr_base] <= dec_bits_i;
    end
  end

  // Age 0 is the slot about to be overwritten, i.e. the oldest entry.
  always_comb begin
    rd_sum = int'(wr_ptr_q) + int'(read_addr_i);
    if (rd_sum >= TBL) begin
      rd_sum = rd_sum - TBL;
    end
    rd_phys     = AW'(rd_sum);
    rd_ok       = (int'(read_addr_i) < TBL) && (int'(read_addr_i) >= TBL - int'(fill_q));
    read_data_o = rd_ok ? mem_q[rd_phys] : '0;
  end

  always_comb begin
    pm_current_o = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_current_o[pm_idx(s, PM_WIDTH) +: PM_WIDTH] = pm_q[s];
    end
  end

  assign best_state_o = best_state_q;
  assign best_pm_o    = best_pm_q;
  assign fill_o       = fill_q;
  assign full_o       = (fill_q == FW'(TBL));
  assign norm_o       = norm_q;

endmodule

// File: tb/tb_pmu_ring.sv
// Randomised and directed bench for pmu_ring against a shift-register reference model.
`timescale 1ns/1ps
module tb_pmu_ring;

  localparam int NS = 4;
  localparam int PW = 8;
  localparam int TD = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic [3:0]  dec_bits_i;
  logic [31:0] pm_new_i;
  logic [3:0]  read_addr_i;
  logic [31:0] pm_current_o;
  logic [3:0]  read_data_o;
  logic [1:0]  best_state_o;
  logic [7:0]  best_pm_o;
  logic [3:0]  fill_o;
  logic        full_o;
  logic        norm_o;

  pmu_ring #(
    .NUM_STATES (NS),
    .PM_WIDTH   (PW),
    .TBL        (TD),
    .INIT_PM    (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .dec_bits_i   (dec_bits_i),
    .pm_new_i     (pm_new_i),
    .read_addr_i  (read_addr_i),
    .pm_current_o (pm_current_o),
    .read_data_o  (read_data_o),
    .best_state_o (best_state_o),
    .best_pm_o    (best_pm_o),
    .fill_o       (fill_o),
    .full_o       (full_o),
    .norm_o       (norm_o)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: metrics as integers, history as a shift register (newest at TD-1).
  int         m_pm [NS];
  logic [3:0] m_sr [TD];
  int         m_fill;
  int         m_norm;
  int         m_best_s;
  int         m_best_pm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic model_step(input bit r, input bit v, input bit f,
                            input logic [3:0] dec, input logic [31:0] pm);
    int p [NS];
    bit all_hi;
    for (int s = 0; s < NS; s++) p[s] = int'(pm[s*PW +: PW]);
    m_norm = 0;
    if (r || f) begin
      for (int s = 0; s < NS; s++) m_pm[s] = 0;
      for (int a = 0; a < TD; a++) m_sr[a] = 4'h0;
      m_fill    = 0;
      m_best_s  = 0;
      m_best_pm = 0;
    end
    if (!r && v) begin
      all_hi = 1'b1;
      for (int s = 0; s < NS; s++) if (p[s] < 128) all_hi = 1'b0;
      m_norm = all_hi ? 1 : 0;
      for (int s = 0; s < NS; s++) m_pm[s] = all_hi ? p[s] - 128 : p[s];
      for (int a = 0; a < TD - 1; a++) m_sr[a] = m_sr[a+1];
      m_sr[TD-1] = dec;
      m_fill = (m_fill < TD) ? m_fill + 1 : TD;
      m_best_s  = 0;
      m_best_pm = m_pm[0];
      for (int s = 1; s < NS; s++) begin
        if (m_pm[s] < m_best_pm) begin
          m_best_pm = m_pm[s];
          m_best_s  = s;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < NS; s++) begin
      check($sformatf("pm%0d", s), 32'(pm_current_o[s*PW +: PW]), 32'(m_pm[s]));
    end
    check("best_state", 32'(best_state_o), 32'(m_best_s));
    check("best_pm", 32'(best_pm_o), 32'(m_best_pm));
    check("fill", 32'(fill_o), 32'(m_fill));
    check("full", 32'(full_o), 32'(m_fill == TD));
    check("norm", 32'(norm_o), 32'(m_norm));
    for (int a = 0; a < 16; a++) begin
      read_addr_i = 4'(a);
      #1;
      check($sformatf("rd%0d", a), 32'(read_data_o), (a < TD) ? 32'(m_sr[a]) : 32'd0);
    end
  endtask

  task automatic apply(input bit r, input bit v, input bit f,
                       input logic [3:0] dec, input logic [31:0] pm);
    rst        = r;
    valid_i    = v;
    flush_i    = f;
    dec_bits_i = dec;
    pm_new_i   = pm;
    @(posedge clk);
    #1;
    model_step(r, v, f, dec, pm);
    check_all();
  endtask

  initial begin
    logic [31:0] rpm;
    bit          rv, rf, rr;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    dec_bits_i = '0; pm_new_i = '0; read_addr_i = '0;

    // Reset, with a write attempted during it that must be ignored
    apply(1, 0, 0, 4'h0, pk(0, 0, 0, 0));
    apply(1, 1, 1, 4'hF, pk(1, 2, 3, 4));

    // Single write
    apply(0, 1, 0, 4'b1010, pk(10, 20, 30, 40));
    check("single_best_pm", 32'(best_pm_o), 32'd10);

    // Wrap
    for (int k = 1; k <= 16; k++) apply(0, 1, 0, 4'(k), pk(k, k + 1, k + 2, k + 3));
    check("wrap_full", 32'(full_o), 32'd1);
    read_addr_i = 4'd0; #1;
    check("wrap_addr0", 32'(read_data_o), 32'b0010);

    // Normalisation, then a non-normalising write
    apply(0, 1, 0, 4'h3, pk(200, 130, 255, 128));
    check("norm_pm0", 32'(pm_current_o[7:0]), 32'd72);
    check("norm_best", 32'(best_state_o), 32'd3);
    apply(0, 1, 0, 4'h4, pk(127, 200, 200, 200));
    check("nonorm_pm1", 32'(pm_current_o[15:8]), 32'd200);

    // Flush alone, then flush with a write
    apply(0, 0, 1, 4'hF, pk(9, 9, 9, 9));
    apply(0, 1, 1, 4'b0101, pk(50, 60, 70, 80));
    check("flushv_fill", 32'(fill_o), 32'd1);

    // Tie, then idle with changing metrics
    apply(0, 1, 0, 4'h6, pk(5, 5, 9, 5));
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 4'(i), pk(200 + i, 130, 140, 150));

    // Random mix
    for (int i = 0; i < 400; i++) begin
      rpm = $urandom;
      if ($urandom_range(0, 3) == 0) rpm = rpm | 32'h8080_8080;
      if ($urandom_range(0, 7) == 0) rpm = {rpm[31:24], rpm[31:24], rpm[7:0], rpm[7:0]};
      rv = ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 99) == 0);
      apply(rr, rv, rf, 4'($urandom), rpm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
